// File: rtl/coin_spawner.sv
// Falling-coin slot manager: spawns coins into free slots, drops them each fall_tick,
// and collects coins that overlap the player's lane inside the hit window.
module coin_spawner #(
  parameter int NUM_SLOTS  = 4,
  parameter int NUM_LANES  = 3,
  parameter int LANE_X0    = 175,
  parameter int LANE_PITCH = 120,
  parameter int LANE_RANGE = 100000,
  parameter int Y_MAX      = 480,
  parameter int HIT_Y_LO   = 400,
  parameter int HIT_Y_HI   = 440,
  parameter int SCORE_W    = 16,
  localparam int YW        = 10,
  localparam int LW        = $clog2(NUM_LANES + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    spawn_tick,
  input  logic                    fall_tick,
  input  logic [19:0]             rnd,
  input  logic [3:0]              speed,
  input  logic [LW-1:0]           player_lane,
  output logic [NUM_SLOTS-1:0]    slot_valid,
  output logic [NUM_SLOTS*LW-1:0] slot_lane,
  output logic [NUM_SLOTS*10-1:0] slot_x,
  output logic [NUM_SLOTS*YW-1:0] slot_y,
  output logic [SCORE_W-1:0]      score,
  output logic                    collect_pulse,
  output logic                    spawn_drop,
  output logic                    full
);

  localparam logic [31:0] SPAN = 32'(NUM_LANES * LANE_RANGE);

  logic [NUM_SLOTS-1:0] valid_q;
  logic [LW-1:0]        lane_q [NUM_SLOTS];
  logic [YW-1:0]        y_q    [NUM_SLOTS];

  logic [LW-1:0]        spawn_lane;
  logic                 do_spawn;
  logic [NUM_SLOTS-1:0] spawn_sel;
  logic [NUM_SLOTS-1:0] hit;
  logic [NUM_SLOTS-1:0] fall_clr;
  logic [YW:0]          y_sum  [NUM_SLOTS];
  logic [4:0]           n_hit;
  logic [SCORE_W:0]     score_sum;
  logic [SCORE_W-1:0]   score_nxt;

  always_comb begin
    spawn_lane = '0;
    if (32'(rnd) < SPAN)
      spawn_lane = LW'(32'(rnd) / 32'(LANE_RANGE) + 32'd1);
  end

  assign do_spawn  = spawn_tick && (spawn_lane != '0);
  // one-hot of the lowest clear bit; all-zero when every slot is busy
  assign spawn_sel = ~valid_q & (valid_q + NUM_SLOTS'(1));

  always_comb begin
    n_hit = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      hit[i] = valid_q[i] && (player_lane != '0) && (lane_q[i] == player_lane) &&
               (y_q[i] >= YW'(HIT_Y_LO)) && (y_q[i] <= YW'(HIT_Y_HI));
      y_sum[i]    = {1'b0, y_q[i]} + (YW+1)'(speed);
      fall_clr[i] = y_sum[i] > (YW+1)'(Y_MAX);
      n_hit       = n_hit + 5'(hit[i]);
    end
  end

  always_comb begin
    score_sum = {1'b0, score} + (SCORE_W+1)'(n_hit);
    score_nxt = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q       <= '0;
      score         <= '0;
      collect_pulse <= 1'b0;
      spawn_drop    <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        lane_q[i] <= '0;
        y_q[i]    <= '0;
      end
    end else begin
      collect_pulse <= |hit;
      spawn_drop    <= do_spawn && (&valid_q);
      score         <= score_nxt;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (hit[i] || (valid_q[i] && fall_tick && fall_clr[i])) begin
          valid_q[i] <= 1'b0;
          lane_q[i]  <= '0;
          y_q[i]     <= '0;
        end else if (valid_q[i] && fall_tick) begin
          y_q[i] <= y_sum[i][YW-1:0];
        end else if (do_spawn && spawn_sel[i]) begin
          valid_q[i] <= 1'b1;
          lane_q[i]  <= spawn_lane;
          y_q[i]     <= '0;
        end
      end
    end
  end

  always_comb begin
    slot_valid = valid_q;
    full       = &valid_q;
    slot_lane  = '0;
    slot_x     = '0;
    slot_y     = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slot_lane[i*LW +: LW] = lane_q[i];
      slot_y[i*YW +: YW]    = y_q[i];
      if (valid_q[i])
        slot_x[i*10 +: 10] = 10'(LANE_X0 + (int'(lane_q[i]) - 1) * LANE_PITCH);
    end
  end

endmodule
